imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter AW, default 13, instruction-memory word-address width (8192 words).
REQ-002 Parameter DW, default 32, instruction/data word width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive loader denials before the loader is forced a grant; range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 if_req  input  1  fetch-unit read request.
REQ-007 if_addr  input  AW  fetch word address (PC).
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_valid  output  1  fetch read data valid.
REQ-010 if_data  output  DW  fetch read data.
REQ-011 ld_req  input  1  loader/debug port request.
REQ-012 ld_we  input  1  loader request is a write (1) or read (0).
REQ-013 ld_lock  input  1  loader requests exclusive ownership after its next grant.
REQ-014 ld_addr  input  AW  loader word address.
REQ-015 ld_wdata  input  DW  loader write data.
REQ-016 ld_gnt  output  1  loader request accepted this cycle.
REQ-017 ld_valid  output  1  loader read data valid, or write acknowledge.
REQ-018 ld_rdata  output  DW  loader read data.
REQ-019 cpu_stall  output  1  high when if_req=1 and if_gnt=0.
REQ-020 mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-021 mem_addr  output  AW;  mem_wdata  output  DW;  mem_rdata  input  DW  (memory read latency is exactly 1 cycle).

Function
REQ-022 States: ARB and LOCKED. At most one grant per cycle. if_gnt and ld_gnt are combinational from the requests, the state and the starvation counter.
REQ-023 ARB, priority order:
- ld_req with starve_cnt==STARVE_MAX: loader wins.
- Otherwise if_req: fetch wins.
- Otherwise ld_req: loader wins.
REQ-024 starve_cnt is 4 bits, reset 0.
- Increments (saturating at STARVE_MAX) each cycle with ld_req=1 and ld_gnt=0.
- Clears on any cycle with ld_gnt=1 or ld_req=0.
REQ-025 ARB->LOCKED on a cycle with ld_gnt=1 and ld_lock=1. LOCKED->ARB on a cycle with ld_lock=0; that cycle is already arbitrated as ARB.
REQ-026 In LOCKED, if_gnt=0 and ld_gnt=ld_req; starve_cnt is held at 0.
REQ-027 On a grant, drive the memory in the same cycle:
- mem_en=1.
- mem_addr = granted address.
- mem_we = ld_we on a loader grant, 0 on a fetch grant.
- mem_wdata = ld_wdata.
REQ-028 With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their previous values, with no toggling.
REQ-029 if_valid is registered: it is high exactly one cycle after each if_gnt, and if_data = mem_rdata in that cycle.
REQ-030 ld_valid is registered: it is high exactly one cycle after each ld_gnt.
- Read: ld_rdata = mem_rdata.
- Write: ld_rdata = 0; ld_valid serves as the write acknowledge.
REQ-031 if_data and ld_rdata are 0 whenever their valid is low.
REQ-032 Back-to-back grants are supported: a grant every cycle yields a valid every cycle (full throughput, 1-cycle latency).
REQ-033 Simultaneous requests in the same cycle as the LOCKED->ARB transition follow REQ-023.
REQ-034 Address inputs are used unmodified; no wrap or bounds logic.

Reset
REQ-035 While rst_n=0:
- State = ARB and starve_cnt = 0.
- if_gnt, ld_gnt, if_valid, ld_valid, cpu_stall, mem_en and mem_we = 0.
- if_data, ld_rdata, mem_addr and mem_wdata = 0.
REQ-036 Reset asserted with an access in flight discards it: no valid is produced after rst_n rises.
REQ-037 The first grant is possible in the first cycle after rst_n rises.

Verification
REQ-038 Fetch only: if_req=1 with if_addr=0,1,2 on consecutive cycles and mem holding 0xA0,0xA1,0xA2 -> if_valid=1 for three consecutive cycles, if_data 0xA0,0xA1,0xA2, cpu_stall=0 throughout.
REQ-039 Starvation: if_req and ld_req held high, STARVE_MAX=4 -> fetch granted 4 cycles, loader granted on the 5th, cpu_stall=1 in that cycle only, pattern repeats.
REQ-040 Lock burst: ld_lock=1, ld_we=1, writes 0x11,0x22 to addresses 5,6 while if_req=1 -> if_gnt=0 and cpu_stall=1 until ld_lock=0; a fetch of address 5 then returns 0x11.
REQ-041 Loader read: ld_req=1, ld_we=0, ld_addr=7 holding 0xDEADBEEF -> ld_valid next cycle with ld_rdata=0xDEADBEEF.
REQ-042 Reset mid-access: rst_n=0 in the cycle after if_gnt -> if_valid=0, state ARB, no valid after release.
REQ-043 Idle: no requests for 10 cycles -> mem_en=0, mem_addr stable, starve_cnt=0.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-ported instruction memory between the
// fetch unit and a loader/debug port. Fetch normally has priority; a loader
// denied STARVE_MAX consecutive cycles is forced through, and a loader can
// lock the memory for an exclusive burst.
//
// Handshake: a request is accepted in the cycle its *_gnt_o is high (grants
// are combinational from requests, state and starvation counter); the memory
// is strobed in that same cycle and the matching *_valid_o pulses exactly one
// cycle later. There is no backpressure on the response side.
module imem_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_valid_o,
  output logic [DW-1:0] if_data_o,
  input  logic          ld_req_i,
  input  logic          ld_we_i,
  input  logic          ld_lock_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  output logic          ld_gnt_o,
  output logic          ld_valid_o,
  output logic [DW-1:0] ld_rdata_o,
  output logic          cpu_stall_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          dbg_state_o,
  output logic [3:0]    dbg_starve_cnt_o
);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          arb_mode;
  logic          if_gnt, ld_gnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          if_valid_q, ld_valid_q, ld_wr_q;

  // Arbitration and next state. A LOCKED cycle with ld_lock low is already
  // arbitrated normally. Grants are suppressed while reset is asserted.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    arb_mode = (state_q == ST_ARB) || !ld_lock_i;
    if (rst_n) begin
      if (arb_mode) begin
        if (ld_req_i && (starve_q == STARVE_LIM)) begin
          ld_gnt = 1'b1;
        end else if (if_req_i) begin
          if_gnt = 1'b1;
        end else if (ld_req_i) begin
          ld_gnt = 1'b1;
        end
        if (ld_req_i && !ld_gnt) begin
          starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        end else begin
          starve_d = 4'd0;
        end
        state_d = (ld_gnt && ld_lock_i) ? ST_LOCKED : ST_ARB;
      end else begin
        ld_gnt   = ld_req_i;
        starve_d = 4'd0;
        state_d  = ST_LOCKED;
      end
    end
  end

  // Arbiter state, starvation counter, held memory bus and response tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      starve_q   <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_valid_q <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      if_valid_q <= if_gnt;
      ld_valid_q <= ld_gnt;
      if (ld_gnt) begin
        ld_wr_q <= ld_we_i;
      end
      if (if_gnt || ld_gnt) begin
        addr_q  <= mem_addr_o;
        wdata_q <= ld_wdata_i;
      end
    end
  end

  // Memory strobes; address and write data hold their last value when idle
  // so the bus does not toggle.
  always_comb begin
    mem_en_o    = if_gnt || ld_gnt;
    mem_we_o    = ld_gnt && ld_we_i;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if (ld_gnt) begin
      mem_addr_o = ld_addr_i;
    end else if (if_gnt) begin
      mem_addr_o = if_addr_i;
    end
    if (if_gnt || ld_gnt) begin
      mem_wdata_o = ld_wdata_i;
    end
  end

  // Response data is zero whenever its valid is low; write acks carry zero.
  always_comb begin
    if_gnt_o         = if_gnt;
    ld_gnt_o         = ld_gnt;
    cpu_stall_o      = rst_n && if_req_i && !if_gnt;
    if_valid_o       = if_valid_q;
    ld_valid_o       = ld_valid_q;
    if_data_o        = if_valid_q ? mem_rdata_i : '0;
    ld_rdata_o       = (ld_valid_q && !ld_wr_q) ? mem_rdata_i : '0;
    dbg_state_o      = state_q;
    dbg_starve_cnt_o = starve_q;
  end

endmodule
